// File: rtl/ddr4_bank_cmd_sequencer.sv
// ddr4_bank_cmd_sequencer: per-bank open-row tracker issuing timed PRE/ACT/RD/WR/PREA to DDR4 pins
module ddr4_bank_cmd_sequencer #(
  parameter int RANKS     = 1,
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRP       = 16,
  parameter int TRCD      = 16,
  parameter int TRRD_S    = 4,
  parameter int TRRD_L    = 6,
  parameter int TCCD      = 4
) (
  input  logic                 ck_t,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  input  logic                 prea_req,
  output logic [RANKS-1:0]     cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 cmd_done
);
  localparam int NB = 1 << (BGWIDTH + BAWIDTH);
  localparam logic [7:0] T_RP = 8'(TRP), T_RCD = 8'(TRCD), T_RRS = 8'(TRRD_S), T_RRL = 8'(TRRD_L), T_CCD = 8'(TCCD);
  typedef enum logic [2:0] {IDLE, DECIDE, PRE, ACT, CAS, PREA} state_t;
  state_t state, state_nx;
  logic                 wr_q;
  logic [BGWIDTH-1:0]   bg_q, last_act_bg;
  logic [BAWIDTH-1:0]   ba_q;
  logic [ADDRWIDTH-1:0] row_q, a_nx;
  logic [COLWIDTH-1:0]  col_q;
  logic [NB-1:0]        open_q;
  logic [ADDRWIDTH-1:0] row_tab [NB];
  logic [7:0]           t_pre, t_act, t_cas;
  logic                 accept, issue_pre, issue_act, issue_cas, issue_prea, issue;
  logic [BGWIDTH+BAWIDTH-1:0] idx;
  assign idx   = {bg_q, ba_q};
  assign issue = issue_pre | issue_act | issue_cas | issue_prea;
  // each counter holds edges elapsed since its command; saturation means satisfied
  function automatic logic [7:0] inc(input logic [7:0] v);
    return v + {7'd0, v != 8'hff};
  endfunction
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    issue_pre  = 1'b0;
    issue_act  = 1'b0;
    issue_cas  = 1'b0;
    issue_prea = 1'b0;
    case (state)
      IDLE:    if (req_ready && prea_req) state_nx = PREA;
               else if (req_ready && req_valid) begin accept = 1'b1; state_nx = DECIDE; end
      DECIDE:  state_nx = !open_q[idx] ? ACT : (row_tab[idx] == row_q ? CAS : PRE);
      PRE:     begin issue_pre = 1'b1; state_nx = ACT; end
      ACT:     if (t_pre >= T_RP && t_act >= (bg_q == last_act_bg ? T_RRL : T_RRS)) begin
                 issue_act = 1'b1;
                 state_nx  = CAS;
               end
      CAS:     if (t_act >= T_RCD && t_cas >= T_CCD) begin issue_cas = 1'b1; state_nx = IDLE; end
      PREA:    if (t_act >= T_RCD) begin issue_prea = 1'b1; state_nx = IDLE; end
      default: state_nx = IDLE;
    endcase
    a_nx                 = '0;
    a_nx[16:14]          = issue_cas ? {2'b10, ~wr_q} : (issue_pre | issue_prea) ? 3'b010 : 3'b000;
    a_nx[10]             = issue_prea;
    a_nx[COLWIDTH-1:0]   = issue_cas ? col_q : '0;
    if (issue_act) a_nx  = row_q;
  end
  always_ff @(posedge ck_t or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      cs_n        <= '1;
      act_n       <= 1'b1;
      A           <= '0;
      bg          <= '0;
      ba          <= '0;
      cmd_done    <= 1'b0;
      open_q      <= '0;
      t_pre       <= 8'hff;
      t_act       <= 8'hff;
      t_cas       <= 8'hff;
      last_act_bg <= '0;
      wr_q        <= 1'b0;
      bg_q        <= '0;
      ba_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
    end else begin
      state     <= state_nx;
      req_ready <= state_nx == IDLE;
      cs_n      <= {RANKS{~issue}};
      act_n     <= ~issue_act;
      A         <= a_nx;
      cmd_done  <= issue_cas | issue_prea;
      if (issue_pre | issue_act | issue_cas) begin
        bg <= bg_q;
        ba <= ba_q;
      end
      if (accept) begin
        wr_q  <= req_write;
        bg_q  <= req_bg;
        ba_q  <= req_ba;
        row_q <= req_row;
        col_q <= req_col;
      end
      if (issue_prea) open_q <= '0;
      else if (issue_pre) open_q[idx] <= 1'b0;
      else if (issue_act) open_q[idx] <= 1'b1;
      if (issue_act) last_act_bg <= bg_q;
      t_pre <= (issue_pre | issue_prea) ? 8'd1 : inc(t_pre);
      t_act <= issue_act ? 8'd1 : inc(t_act);
      t_cas <= issue_cas ? 8'd1 : inc(t_cas);
    end
  end
  always_ff @(posedge ck_t) if (issue_act) row_tab[idx] <= row_q;
endmodule

// File: doc/ddr4_bank_cmd_sequencer.md
Name: ddr4_bank_cmd_sequencer

Overview:
- Upstream command stage for the DDR4 `dimm` emulator.
- Accepts one memory request at a time (read/write, bank group, bank, row, column) on a valid/ready handshake and keeps a per-bank open-row table.
- Drives the DIMM command pins (cs_n, act_n, A, bg, ba) with the correct PRE/ACT/RD/WR sequence.
- Enforces tRP, tRCD, tRRD_S/tRRD_L and tCCD so that bank-interleaved traffic reaches the DIMM legally.

Parameters:
- RANKS, 1, number of chip-select lines.
- BGWIDTH, 2, bank-group address width.
- BAWIDTH, 2, bank address width.
- ADDRWIDTH, 17, row/command address width.
- COLWIDTH, 10, column address width.
- TRP, 16, PRE to ACT, same bank, in cycles.
- TRCD, 16, ACT to RD/WR, in cycles.
- TRRD_S, 4, ACT to ACT, different bank group.
- TRRD_L, 6, ACT to ACT, same bank group.
- TCCD, 4, CAS to CAS.

Ports:
- ck_t, input, 1, clock; all logic on the rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- req_valid, input, 1, request present.
- req_ready, output, 1, sequencer can accept a request.
- req_write, input, 1, 1 = WR, 0 = RD.
- req_bg, input, BGWIDTH, target bank group.
- req_ba, input, BAWIDTH, target bank.
- req_row, input, ADDRWIDTH, target row.
- req_col, input, COLWIDTH, target column.
- prea_req, input, 1, precharge-all request (level, sampled in IDLE).
- cs_n, output, RANKS, chip select (all ranks driven identically).
- act_n, output, 1, DDR4 ACT_n.
- A, output, ADDRWIDTH, row address, or RAS_n/CAS_n/WE_n on A[16:14] plus column.
- bg, output, BGWIDTH, command bank group.
- ba, output, BAWIDTH, command bank.
- cmd_done, output, 1, one-cycle pulse coincident with the RD/WR or PREA on the pins.

Behaviour:

Reset and output registers:
- All outputs are registered.
- Reset (asynchronous, any time, including mid-sequence) forces:
  - cs_n all 1, act_n 1, A 0, bg 0, ba 0, cmd_done 0, req_ready 0.
  - FSM to IDLE, all banks marked closed.
  - All timing counters saturated (every constraint satisfied).
  - Any in-flight request dropped.
- req_ready rises on the first edge after reset release.

Deselect cycles:
- In any cycle with no command issued: cs_n all 1, act_n 1, A 0.
- bg and ba hold their last values.

Command encodings (cs_n 0 in all cases):
- ACT: act_n 0, A = row.
- RD: act_n 1, A[16:14] = 101, A[10] = 0, A[COLWIDTH-1:0] = col.
- WR: act_n 1, A[16:14] = 100, A[10] = 0, A[COLWIDTH-1:0] = col.
- PRE: act_n 1, A[16:14] = 010, A[10] = 0.
- PREA: as PRE with A[10] = 1.
- Unused A bits are 0.

Timing rule:
- A constrained command may appear on the pins at edge e only if e − (edge at which the constraining command appeared) ≥ T.
- Before the first occurrence of a constraining command, the constraint is satisfied.

FSM:
- IDLE: req_ready = 1.
  - prea_req has priority: go to PREA with req_ready 0.
  - Otherwise req_valid & req_ready captures the request and goes to DECIDE.
- DECIDE (1 cycle):
  - Bank open with matching row (hit) → CAS.
  - Bank open with a different row (miss) → PRE.
  - Bank closed → ACT.
- PRE: issue PRE to the captured bank; mark it closed; → ACT.
- ACT:
  - Wait for TRP since the last PRE/PREA.
  - Wait for TRRD_L if bg equals the bg of the last ACT, otherwise TRRD_S.
  - Issue ACT; record the row as open; → CAS.
- CAS: wait for TRCD since the ACT and TCCD since the last CAS; issue RD/WR; pulse cmd_done; → IDLE.
- PREA: wait for TRCD since the last ACT; issue PREA; mark all banks closed; pulse cmd_done; → IDLE.

Latency (request accepted at edge t):
- Hit: RD/WR on pins at t+2, if TCCD is met.
- Closed bank: ACT at t+2, RD/WR at ACT+TRCD.
- Miss: PRE at t+2, ACT at PRE+TRP, RD/WR at ACT+TRCD.
- Pipeline bound: back-to-back requests give a minimum ACT-to-ACT spacing of TRCD+3.

Boundaries:
- req_valid and prea_req together in IDLE: PREA is served first and the request waits.
- req_* fields are ignored outside the accept edge.
- Counters saturate; no wrap-around.

Test Plan:
- Reset: hold reset_n=0 with req_valid=1 → cs_n=1, act_n=1, A=0, req_ready=0, no command. Assert reset_n=0 mid-ACT-wait → outputs return to reset values immediately.
- Closed bank, defaults: RD bg0 ba0 row 1 col 8 accepted at edge 10 →
  - ACT (A=1) at edge 12.
  - RD at edge 28 with A[16:14]=101, A[9:0]=8, cmd_done=1.
- Row hit + tCCD: after that RD (edge 28), RD same bank row 1 col 16 accepted at edge 29 → no ACT; RD at edge 32 (TCCD=4, not 31).
- Row miss: WR bg0 ba0 row 9 →
  - PRE (A[16:14]=010, A10=0) at accept+2.
  - ACT A=9 at PRE+16.
  - WR (A[16:14]=100) at ACT+16.
- tRRD with TRCD=2, TRRD_L=8, TRRD_S=4, requests held valid:
  - Closed bg0 ba0 then bg0 ba1 → ACT spacing 8.
  - bg0 ba2 then bg1 ba0 → ACT spacing 5.
  - All 16 banks in order → every ACT legal, all open.
- PREA: banks open, prea_req=1 with req_valid=1 → PREA (A10=1) issued before the request. The request to a previously open row then issues ACT ≥ TRP later.
